// File: rtl/func_call_arbiter.sv
// Round-robin arbiter that serialises calls from NUM_REQ requesters onto one
// multi-cycle evaluation of result = arg + OFFSET, tagging each result with its caller.
module func_call_arbiter #(
    parameter int          NUM_REQ = 2,
    parameter int          WIDTH   = 32,
    parameter int          LATENCY = 3,
    parameter logic [31:0] OFFSET  = 32'd5,
    localparam int         ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_arg,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy
);

    localparam int               CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   arg_q;
    logic [ID_W-1:0]    id_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W:0]      sum;
    logic               found;
    logic               hs;
    logic [WIDTH-1:0]   sel_arg;

    // The evaluated function; the sum wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] eval_call(input logic [WIDTH-1:0] arg);
        return arg + OFF_W;
    endfunction

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = sum[ID_W-1:0];
            end
        end
        grant[gnt_idx] = found;
    end

    always_comb begin
        sel_arg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i))
                sel_arg = req_arg[i*WIDTH +: WIDTH];
        end
    end

    assign next_ptr  = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    assign req_ready = (state == IDLE) ? grant : '0;
    assign hs        = (state == IDLE) && found;

    // Call capture: reset suppresses a handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (hs && !rst) begin
            arg_q <= sel_arg;
            id_q  <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (hs) begin
                        cnt    <= CNT_W'(LATENCY-1);
                        rr_ptr <= next_ptr;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        resp_data  <= eval_call(arg_q);
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_func_call_arbiter.sv
// Directed bench for func_call_arbiter: a default instance (2 requesters, latency 3)
// and a 3-requester, latency-1 instance, checked with immediate assertions.
module tb_func_call_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req_valid;
    logic [63:0] req_arg;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic [0:0]  resp_id;
    logic [31:0] resp_data;
    logic        busy;

    logic [2:0]  v3;
    logic [95:0] a3;
    logic [2:0]  rdy3;
    logic        rv3;
    logic [1:0]  rid3;
    logic [31:0] rd3;
    logic        busy3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    func_call_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_arg(req_arg), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy)
    );

    func_call_arbiter #(.NUM_REQ(3), .LATENCY(1)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_arg(a3), .req_ready(rdy3),
        .resp_valid(rv3), .resp_id(rid3), .resp_data(rd3),
        .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_arg = '0;
        v3 = '0;
        a3 = '0;
        tick();
        tick();

        // Reset state
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy3", busy3, 0);
        chk("rst_resp_valid3", rv3, 0);
        rst = 1'b0;
        tick();

        // 1: single request from requester 1
        req_valid = 2'b10;
        req_arg[63:32] = 32'd10;
        #1;
        chk("t1_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= 3; c++) begin
            chk("t1_busy", busy, 1);
            chk("t1_no_resp", resp_valid, 0);
            chk("t1_ready_busy", req_ready, 0);
            tick();
        end
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_id", resp_id, 1);
        chk("t1_resp_data", resp_data, 32'd15);
        chk("t1_busy_done", busy, 1);
        tick();
        chk("t1_resp_pulse", resp_valid, 0);
        chk("t1_busy_idle", busy, 0);

        // 2: simultaneous requests after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b11;
        req_arg = {32'd7, 32'd0};
        #1;
        chk("t2_ready_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        #1;
        chk("t2_ready_busy", req_ready, 2'b00);
        tick();
        tick();
        tick();
        chk("t2_resp0_valid", resp_valid, 1);
        chk("t2_resp0_id", resp_id, 0);
        chk("t2_resp0_data", resp_data, 32'd5);
        chk("t2_ready_done", req_ready, 2'b00);
        tick();
        chk("t2_ready_second", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("t2_resp1_valid", resp_valid, 1);
        chk("t2_resp1_id", resp_id, 1);
        chk("t2_resp1_data", resp_data, 32'd12);
        tick();

        // 3: fairness with both requesters held valid
        req_valid = 2'b11;
        req_arg = {32'd200, 32'd100};
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("t3_grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            tick();
            tick();
            tick();
            chk("t3_resp_valid", resp_valid, 1);
            chk("t3_resp_id", resp_id, g % 2);
            chk("t3_resp_data", resp_data, (g % 2 == 0) ? 32'd105 : 32'd205);
            tick();
        end
        req_valid = 2'b00;

        // 4: wrap-around of the sum
        req_valid = 2'b01;
        req_arg[31:0] = 32'hFFFF_FFFE;
        #1;
        chk("t4_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("t4_resp_valid", resp_valid, 1);
        chk("t4_resp_id", resp_id, 0);
        chk("t4_resp_data", resp_data, 32'd3);
        tick();

        // 5: reset during the second BUSY cycle
        req_valid = 2'b01;
        req_arg[31:0] = 32'd9;
        #1;
        chk("t5_ready_wrap", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy_after_rst", busy, 0);
        for (int c = 0; c < 5; c++) begin
            chk("t5_no_resp", resp_valid, 0);
            tick();
        end
        req_valid = 2'b11;
        #1;
        chk("t5_ptr_zero", req_ready, 2'b01);
        req_valid = 2'b10;
        req_arg[63:32] = 32'd1;
        #1;
        chk("t5_ready_req1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("t5_resp_valid", resp_valid, 1);
        chk("t5_resp_id", resp_id, 1);
        chk("t5_resp_data", resp_data, 32'd6);
        tick();

        // 6: LATENCY=1, three requesters all valid
        v3 = 3'b111;
        a3 = {32'd30, 32'd20, 32'd10};
        #1;
        chk("t6_ready0", rdy3, 3'b001);
        tick();
        v3 = 3'b110;
        chk("t6_busy_cycle0", rv3, 0);
        chk("t6_busy3", busy3, 1);
        tick();
        chk("t6_resp0_valid", rv3, 1);
        chk("t6_resp0_id", rid3, 0);
        chk("t6_resp0_data", rd3, 32'd15);
        chk("t6_ready_done", rdy3, 3'b000);
        tick();
        chk("t6_idle_gap0", rv3, 0);
        chk("t6_ready1", rdy3, 3'b010);
        tick();
        v3 = 3'b100;
        chk("t6_busy_cycle1", rv3, 0);
        tick();
        chk("t6_resp1_valid", rv3, 1);
        chk("t6_resp1_id", rid3, 1);
        chk("t6_resp1_data", rd3, 32'd25);
        tick();
        chk("t6_idle_gap1", rv3, 0);
        chk("t6_ready2", rdy3, 3'b100);
        tick();
        v3 = 3'b000;
        chk("t6_busy_cycle2", rv3, 0);
        tick();
        chk("t6_resp2_valid", rv3, 1);
        chk("t6_resp2_id", rid3, 2);
        chk("t6_resp2_data", rd3, 32'd35);
        tick();
        chk("t6_end_idle", busy3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
